// File: rtl/snoop_responder_if.sv
// ============================================================================
// Module      : snoop_responder_if
// Description : Coherence-bus op broadcast and write-back handshake bundle
//               between the bus/memory side and one snoop responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snoop_responder_if #(
    parameter int AW     = 16,
    parameter int LINE_W = 64
);
    // Op broadcast from the bus arbiter
    logic              op_valid;
    logic [1:0]        op;
    logic              cpu_doing_curr_op;
    logic [AW-1:0]     bus_addr;

    // Write-back channel towards memory
    logic              wb_valid;
    logic              wb_ready;
    logic [AW-1:0]     wb_addr;
    logic [LINE_W-1:0] wb_data;

    modport master (
        output op_valid,
        output op,
        output cpu_doing_curr_op,
        output bus_addr,
        output wb_ready,
        input  wb_valid,
        input  wb_addr,
        input  wb_data
    );

    modport slave (
        input  op_valid,
        input  op,
        input  cpu_doing_curr_op,
        input  bus_addr,
        input  wb_ready,
        output wb_valid,
        output wb_addr,
        output wb_data
    );
endinterface

`default_nettype wire

// File: rtl/snoop_responder.sv
// ============================================================================
// Module      : snoop_responder
// Description : Per-core MSI snoop responder; flushes, downgrades or
//               invalidates the local line for ops issued by the other core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoop_responder #(
    parameter int CORE_ID = 0,
    parameter int AW      = 16,
    parameter int IDX_W   = 4,
    parameter int OFF_W   = 2,
    parameter int LINE_W  = 64
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    snoop_responder_if.slave                 bus,

    output logic [IDX_W-1:0]                 tag_rd_idx,
    input  wire logic [AW-IDX_W-OFF_W-1:0]   tag_rd_tag,
    input  wire logic [1:0]                  tag_rd_state,

    output logic [IDX_W-1:0]                 data_rd_idx,
    input  wire logic [LINE_W-1:0]           data_rd_data,

    output logic                             st_wr_en,
    output logic [IDX_W-1:0]                 st_wr_idx,
    output logic [1:0]                       st_wr_state,

    output logic                             snoop_busy,
    output logic                             snoop_hit,
    output logic                             snoop_done,
    output logic                             snoop_overrun
);

    localparam int         TAG_W         = AW - IDX_W - OFF_W;
    localparam logic       CORE_BIT      = 1'(CORE_ID);
    localparam logic [1:0] OP_READ_MISS  = 2'b01;
    localparam logic [1:0] OP_WRITE_MISS = 2'b10;
    localparam logic [1:0] ST_I          = 2'b00;
    localparam logic [1:0] ST_S          = 2'b01;
    localparam logic [1:0] ST_M          = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_COMPARE = 3'd2,
        S_DATA    = 3'd3,
        S_WB      = 3'd4,
        S_UPDATE  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              state_q,    state_d;
    logic                is_write_q, is_write_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [TAG_W-1:0]    tag_q,      tag_d;
    logic [LINE_W-1:0]   wb_data_q,  wb_data_d;
    logic                overrun_q,  overrun_d;

    logic                w_accept;
    logic                w_hit;

    // Only real misses from the other core are snooped; NOOP and 2'b11 fall out here.
    assign w_accept = bus.op_valid
                    && ((bus.op == OP_READ_MISS) || (bus.op == OP_WRITE_MISS))
                    && (bus.cpu_doing_curr_op != CORE_BIT);

    assign w_hit = (tag_rd_state != ST_I) && (tag_rd_tag == tag_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            tag_q      <= '0;
            wb_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            wb_data_q  <= wb_data_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        wb_data_d  = wb_data_q;
        overrun_d  = overrun_q;

        if (bus.op_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    is_write_d = (bus.op == OP_WRITE_MISS);
                    idx_d      = bus.bus_addr[OFF_W +: IDX_W];
                    tag_d      = bus.bus_addr[AW-1 : OFF_W+IDX_W];
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (!w_hit) begin
                    state_d = S_DONE;
                end else if (tag_rd_state == ST_M) begin
                    state_d = S_DATA;
                end else if (is_write_q) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DATA: begin
                // Read was issued from COMPARE, so the line is already on data_rd_data.
                wb_data_d = data_rd_data;
                state_d   = S_WB;
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tag_rd_idx   = '0;
        data_rd_idx  = '0;
        st_wr_en     = 1'b0;
        st_wr_idx    = '0;
        st_wr_state  = ST_I;
        snoop_hit    = 1'b0;
        bus.wb_valid = 1'b0;

        case (state_q)
            S_LOOKUP: begin
                tag_rd_idx = idx_q;
            end
            S_COMPARE: begin
                tag_rd_idx  = idx_q;
                data_rd_idx = idx_q;
                snoop_hit   = w_hit;
            end
            S_DATA: begin
                data_rd_idx = idx_q;
            end
            S_WB: begin
                bus.wb_valid = 1'b1;
            end
            S_UPDATE: begin
                st_wr_en    = 1'b1;
                st_wr_idx   = idx_q;
                st_wr_state = is_write_q ? ST_I : ST_S;
            end
            default: begin
            end
        endcase
    end

    assign bus.wb_addr    = {tag_q, idx_q, {OFF_W{1'b0}}};
    assign bus.wb_data    = wb_data_q;
    assign snoop_busy     = (state_q != S_IDLE);
    assign snoop_done     = (state_q == S_DONE);
    assign snoop_overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_snoop_responder.sv
// ============================================================================
// Module      : tb_snoop_responder
// Description : Self-checking bench for snoop_responder (CORE_ID = 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snoop_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snoop_responder_if #(.AW(16), .LINE_W(64)) bus_if ();

    logic [3:0]  tag_rd_idx, data_rd_idx, st_wr_idx;
    logic [9:0]  tag_rd_tag;
    logic [1:0]  tag_rd_state, st_wr_state;
    logic [63:0] data_rd_data;
    logic        st_wr_en, snoop_busy, snoop_hit, snoop_done, snoop_overrun;

    snoop_responder #(.CORE_ID(0), .AW(16), .IDX_W(4), .OFF_W(2), .LINE_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_if.slave),
        .tag_rd_idx    (tag_rd_idx),
        .tag_rd_tag    (tag_rd_tag),
        .tag_rd_state  (tag_rd_state),
        .data_rd_idx   (data_rd_idx),
        .data_rd_data  (data_rd_data),
        .st_wr_en      (st_wr_en),
        .st_wr_idx     (st_wr_idx),
        .st_wr_state   (st_wr_state),
        .snoop_busy    (snoop_busy),
        .snoop_hit     (snoop_hit),
        .snoop_done    (snoop_done),
        .snoop_overrun (snoop_overrun)
    );

    // Cache arrays with 1-cycle registered read ports
    logic [9:0]  tag_mem  [16];
    logic [1:0]  st_mem   [16];
    logic [63:0] data_mem [16];

    always @(posedge clk) begin
        tag_rd_tag   <= tag_mem[tag_rd_idx];
        tag_rd_state <= st_mem[tag_rd_idx];
        data_rd_data <= data_mem[data_rd_idx];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one transaction (cycle 0 = op_valid cycle)
    bit          obs_busy_any, obs_hit, obs_hit_stray, obs_wb_moved;
    int          obs_done_cyc, obs_done_cnt, obs_wr_cyc, obs_wr_cnt, obs_wb_first, obs_wb_cnt;
    logic [3:0]  obs_wr_idx;
    logic [1:0]  obs_wr_state;
    logic [15:0] obs_wb_addr;
    logic [63:0] obs_wb_data;

    // Reference expectations
    bit          exp_accept, exp_hit;
    int          exp_done, exp_wr_cyc, exp_wb_first, exp_wb_cnt;
    logic [3:0]  exp_wr_idx;
    logic [1:0]  exp_wr_state;
    logic [15:0] exp_wb_addr;
    logic [63:0] exp_wb_data;

    task automatic set_line(input logic [3:0] idx, input logic [9:0] tg, input logic [1:0] st,
                            input logic [63:0] dat);
        tag_mem[idx]  = tg;
        st_mem[idx]   = st;
        data_mem[idx] = dat;
    endtask

    // MSI snoop rules applied to the current array contents; d = wb_ready stall cycles.
    task automatic predict(input logic [1:0] o, input logic id, input logic [15:0] a, input int d);
        logic [3:0] idx;
        logic [9:0] tg;
        idx          = a[5:2];
        tg           = a[15:6];
        exp_accept   = ((o == 2'b01) || (o == 2'b10)) && (id != 1'b0);
        exp_hit      = exp_accept && (st_mem[idx] != 2'b00) && (tag_mem[idx] == tg);
        exp_done     = -1;
        exp_wr_cyc   = -1;
        exp_wb_first = -1;
        exp_wb_cnt   = 0;
        exp_wr_idx   = idx;
        exp_wr_state = 2'b00;
        exp_wb_addr  = a & 16'hFFFC;
        exp_wb_data  = data_mem[idx];
        if (exp_accept) begin
            if (!exp_hit) begin
                exp_done = 3;
            end else if (st_mem[idx] == 2'b10) begin
                exp_wb_first = 4;
                exp_wb_cnt   = d + 1;
                exp_wr_cyc   = 5 + d;
                exp_wr_state = (o == 2'b10) ? 2'b00 : 2'b01;
                exp_done     = 6 + d;
            end else if (o == 2'b10) begin
                exp_wr_cyc = 3;
                exp_done   = 4;
            end else begin
                exp_done = 3;
            end
        end
    endtask

    // Issue one op and record per-cycle behaviour for `budget` cycles.
    // d: cycles wb_ready is held low once wb_valid appears; inj: cycle of an extra op_valid.
    task automatic do_op(input logic [1:0] o, input logic id, input logic [15:0] a,
                         input int d, input int budget, input int inj);
        int stall;
        stall         = 0;
        obs_busy_any  = 0; obs_hit = 0; obs_hit_stray = 0; obs_wb_moved = 0;
        obs_done_cyc  = -1; obs_done_cnt = 0; obs_wr_cyc = -1; obs_wr_cnt = 0;
        obs_wb_first  = -1; obs_wb_cnt = 0;
        obs_wr_idx    = '0; obs_wr_state = '0; obs_wb_addr = '0; obs_wb_data = '0;
        @(negedge clk);
        bus_if.op_valid          = 1'b1;
        bus_if.op                = o;
        bus_if.cpu_doing_curr_op = id;
        bus_if.bus_addr          = a;
        bus_if.wb_ready          = 1'b0;
        if (snoop_busy) obs_busy_any = 1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            bus_if.op_valid = (n == inj);
            if (n == inj) begin
                bus_if.op                = 2'b01;
                bus_if.cpu_doing_curr_op = 1'b1;
                bus_if.bus_addr          = ~a;
            end
            if (snoop_busy) obs_busy_any = 1;
            if (n == 2) obs_hit = snoop_hit;
            else if (snoop_hit) obs_hit_stray = 1;
            if (snoop_done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = n;
            end
            if (st_wr_en) begin
                obs_wr_cnt++;
                if (obs_wr_cyc < 0) begin
                    obs_wr_cyc   = n;
                    obs_wr_idx   = st_wr_idx;
                    obs_wr_state = st_wr_state;
                end
            end
            if (bus_if.wb_valid) begin
                if (obs_wb_first < 0) begin
                    obs_wb_first = n;
                    obs_wb_addr  = bus_if.wb_addr;
                    obs_wb_data  = bus_if.wb_data;
                end else if ((bus_if.wb_addr !== obs_wb_addr) || (bus_if.wb_data !== obs_wb_data)) begin
                    obs_wb_moved = 1;
                end
                obs_wb_cnt++;
                if (stall < d) stall++;
                else bus_if.wb_ready = 1'b1;
            end else begin
                bus_if.wb_ready = 1'b0;
            end
        end
        bus_if.op_valid = 1'b0;
        bus_if.wb_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({snoop_busy, snoop_hit, snoop_done, snoop_overrun, st_wr_en, bus_if.wb_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {snoop_busy, snoop_hit, snoop_done, snoop_overrun, st_wr_en, bus_if.wb_valid});
        end
        n_checks++;
        if ({bus_if.wb_addr, bus_if.wb_data, tag_rd_idx, data_rd_idx, st_wr_idx, st_wr_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: got addr=%h data=%h tidx=%h didx=%h widx=%h wst=%h want all 0",
                     bus_if.wb_addr, bus_if.wb_data, tag_rd_idx, data_rd_idx, st_wr_idx, st_wr_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_m_read_flush;
        set_line(4'd9, 10'h004, 2'b10, 64'hDEAD_BEEF_0123_4567);
        do_op(2'b01, 1'b1, 16'h0124, 0, 10, -1);
        n_checks++;
        if (obs_wb_first !== 4 || obs_wb_cnt !== 1) begin
            n_fail++;
            $display("FAIL mread_wb: got first=%0d cnt=%0d want first=4 cnt=1", obs_wb_first, obs_wb_cnt);
        end
        n_checks++;
        if (obs_wb_addr !== 16'h0124 || obs_wb_data !== 64'hDEAD_BEEF_0123_4567) begin
            n_fail++;
            $display("FAIL mread_wbdata: got %h/%h want 0124/deadbeef01234567", obs_wb_addr, obs_wb_data);
        end
        n_checks++;
        if (obs_wr_cyc !== 5 || obs_wr_idx !== 4'd9 || obs_wr_state !== 2'b01 || obs_wr_cnt !== 1) begin
            n_fail++;
            $display("FAIL mread_wr: got cyc=%0d idx=%0d st=%b cnt=%0d want 5/9/01/1",
                     obs_wr_cyc, obs_wr_idx, obs_wr_state, obs_wr_cnt);
        end
        n_checks++;
        if (obs_done_cyc !== 6 || obs_done_cnt !== 1 || obs_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL mread_done: got done=%0d cnt=%0d hit=%b want 6/1/1", obs_done_cyc, obs_done_cnt, obs_hit);
        end
    endtask

    task automatic test_s_write_inval;
        set_line(4'd0, 10'h001, 2'b01, 64'h1111_2222_3333_4444);
        do_op(2'b10, 1'b1, 16'h0040, 0, 8, -1);
        n_checks++;
        if (obs_wr_cyc !== 3 || obs_wr_state !== 2'b00 || obs_wr_idx !== 4'd0 || obs_wr_cnt !== 1) begin
            n_fail++;
            $display("FAIL swrite_wr: got cyc=%0d st=%b idx=%0d cnt=%0d want 3/00/0/1",
                     obs_wr_cyc, obs_wr_state, obs_wr_idx, obs_wr_cnt);
        end
        n_checks++;
        if (obs_wb_cnt !== 0 || obs_done_cyc !== 4) begin
            n_fail++;
            $display("FAIL swrite_done: got wbcnt=%0d done=%0d want 0/4", obs_wb_cnt, obs_done_cyc);
        end
    endtask

    task automatic test_own_core;
        set_line(4'd3, 10'h000, 2'b10, 64'h5);
        do_op(2'b01, 1'b0, 16'h000C, 0, 10, -1);
        n_checks++;
        if (obs_busy_any !== 1'b0 || obs_done_cnt !== 0 || obs_wr_cnt !== 0 || obs_wb_cnt !== 0) begin
            n_fail++;
            $display("FAIL own_core: got busy=%b done=%0d wr=%0d wb=%0d want all 0",
                     obs_busy_any, obs_done_cnt, obs_wr_cnt, obs_wb_cnt);
        end
    endtask

    task automatic test_tag_mismatch;
        set_line(4'd9, 10'h3FF, 2'b10, 64'hABCD);
        do_op(2'b01, 1'b1, 16'h0124, 0, 8, -1);
        n_checks++;
        if (obs_hit !== 1'b0 || obs_done_cyc !== 3 || obs_wb_cnt !== 0 || obs_wr_cnt !== 0) begin
            n_fail++;
            $display("FAIL tag_miss: got hit=%b done=%0d wb=%0d wr=%0d want 0/3/0/0",
                     obs_hit, obs_done_cyc, obs_wb_cnt, obs_wr_cnt);
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic        id;
        logic [15:0] a;
        int          d;
        for (int t = 0; t < 40; t++) begin
            o  = 2'($urandom_range(0, 3));
            id = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            d  = $urandom_range(0, 3);
            set_line(a[5:2], ($urandom_range(0, 1) == 1) ? a[15:6] : 10'($urandom),
                     2'($urandom_range(0, 2)), {$urandom, $urandom});
            predict(o, id, a, d);
            do_op(o, id, a, d, (exp_done < 0) ? 10 : exp_done + 3, -1);
            n_checks++;
            if (obs_busy_any !== exp_accept || obs_hit !== exp_hit || obs_hit_stray !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_busyhit: got busy=%b hit=%b stray=%b want %b/%b/0",
                         t, obs_busy_any, obs_hit, obs_hit_stray, exp_accept, exp_hit);
            end
            n_checks++;
            if (obs_done_cyc !== exp_done || obs_done_cnt !== (exp_done < 0 ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rnd%0d_done: got cyc=%0d cnt=%0d want cyc=%0d", t, obs_done_cyc, obs_done_cnt, exp_done);
            end
            n_checks++;
            if (obs_wr_cyc !== exp_wr_cyc || obs_wr_cnt !== (exp_wr_cyc < 0 ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rnd%0d_wrcyc: got cyc=%0d cnt=%0d want cyc=%0d", t, obs_wr_cyc, obs_wr_cnt, exp_wr_cyc);
            end
            if (exp_wr_cyc >= 0) begin
                n_checks++;
                if (obs_wr_idx !== exp_wr_idx || obs_wr_state !== exp_wr_state) begin
                    n_fail++;
                    $display("FAIL rnd%0d_wr: got idx=%0d st=%b want idx=%0d st=%b",
                             t, obs_wr_idx, obs_wr_state, exp_wr_idx, exp_wr_state);
                end
            end
            n_checks++;
            if (obs_wb_first !== exp_wb_first || obs_wb_cnt !== exp_wb_cnt || obs_wb_moved !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_wbtime: got first=%0d cnt=%0d moved=%b want %0d/%0d/0",
                         t, obs_wb_first, obs_wb_cnt, obs_wb_moved, exp_wb_first, exp_wb_cnt);
            end
            if (exp_wb_first >= 0) begin
                n_checks++;
                if (obs_wb_addr !== exp_wb_addr || obs_wb_data !== exp_wb_data) begin
                    n_fail++;
                    $display("FAIL rnd%0d_wbdata: got %h/%h want %h/%h",
                             t, obs_wb_addr, obs_wb_data, exp_wb_addr, exp_wb_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        set_line(4'd2, 10'h055, 2'b00, 64'h0);
        set_line(4'd7, 10'h011, 2'b01, 64'h0);
        do_op(2'b01, 1'b1, 16'h1548, 0, 3, -1);
        n_checks++;
        if (obs_done_cyc !== 3) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%0d want 3", obs_done_cyc);
        end
        // Second op lands the cycle right after DONE.
        do_op(2'b10, 1'b1, 16'h045C, 0, 7, -1);
        n_checks++;
        if (obs_hit !== 1'b1 || obs_wr_cyc !== 3 || obs_wr_idx !== 4'd7 || obs_done_cyc !== 4) begin
            n_fail++;
            $display("FAIL b2b_second: got hit=%b wr=%0d idx=%0d done=%0d want 1/3/7/4",
                     obs_hit, obs_wr_cyc, obs_wr_idx, obs_done_cyc);
        end
        n_checks++;
        if (snoop_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: got %b want 0", snoop_overrun);
        end
    endtask

    task automatic test_wb_stall_overrun;
        set_line(4'd12, 10'h2A5, 2'b10, 64'hCAFE_F00D_8BAD_F00D);
        n_checks++;
        if (snoop_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_pre_overrun: got %b want 0", snoop_overrun);
        end
        do_op(2'b10, 1'b1, 16'hA972, 5, 14, 6);
        n_checks++;
        if (obs_wb_first !== 4 || obs_wb_cnt !== 6 || obs_wb_moved !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_wb: got first=%0d cnt=%0d moved=%b want 4/6/0", obs_wb_first, obs_wb_cnt, obs_wb_moved);
        end
        n_checks++;
        if (obs_wb_addr !== 16'hA970 || obs_wb_data !== 64'hCAFE_F00D_8BAD_F00D) begin
            n_fail++;
            $display("FAIL stall_wbdata: got %h/%h want a970/cafef00d8badf00d", obs_wb_addr, obs_wb_data);
        end
        n_checks++;
        if (obs_wr_cyc !== 10 || obs_wr_state !== 2'b00 || obs_wr_cnt !== 1 || obs_done_cyc !== 11 || obs_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL stall_wr: got wr=%0d st=%b cnt=%0d done=%0d dcnt=%0d want 10/00/1/11/1",
                     obs_wr_cyc, obs_wr_state, obs_wr_cnt, obs_done_cyc, obs_done_cnt);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (snoop_overrun !== 1'b1 || snoop_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_overrun: got overrun=%b busy=%b want 1/0", snoop_overrun, snoop_busy);
        end
    endtask

    task automatic test_reset_mid_wb;
        bit seen;
        set_line(4'd5, 10'h0F0, 2'b10, 64'h7777);
        @(negedge clk);
        bus_if.op_valid          = 1'b1;
        bus_if.op                = 2'b10;
        bus_if.cpu_doing_curr_op = 1'b1;
        bus_if.bus_addr          = 16'h3C14;
        bus_if.wb_ready          = 1'b0;
        seen = 0;
        for (int n = 1; n <= 10 && !seen; n++) begin
            @(negedge clk);
            bus_if.op_valid = 1'b0;
            if (bus_if.wb_valid) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rstwb_reach: got wb_valid never want wb_valid within 10 cycles");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.wb_valid, snoop_busy, st_wr_en, snoop_done, snoop_overrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstwb_async: got %b want 00000",
                     {bus_if.wb_valid, snoop_busy, st_wr_en, snoop_done, snoop_overrun});
        end
        n_checks++;
        if (bus_if.wb_addr !== 16'h0 || bus_if.wb_data !== 64'h0) begin
            n_fail++;
            $display("FAIL rstwb_bus: got %h/%h want 0/0", bus_if.wb_addr, bus_if.wb_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_line(4'd5, 10'h0F0, 2'b01, 64'h7777);
        do_op(2'b01, 1'b1, 16'h3C14, 0, 7, -1);
        n_checks++;
        if (obs_hit !== 1'b1 || obs_done_cyc !== 3 || obs_wr_cnt !== 0 || obs_wb_cnt !== 0) begin
            n_fail++;
            $display("FAIL rstwb_after: got hit=%b done=%0d wr=%0d wb=%0d want 1/3/0/0",
                     obs_hit, obs_done_cyc, obs_wr_cnt, obs_wb_cnt);
        end
    endtask

    initial begin
        bus_if.op_valid          = 1'b0;
        bus_if.op                = 2'b00;
        bus_if.cpu_doing_curr_op = 1'b0;
        bus_if.bus_addr          = '0;
        bus_if.wb_ready          = 1'b0;
        for (int i = 0; i < 16; i++) set_line(4'(i), '0, 2'b00, '0);
        test_reset;
        test_m_read_flush;
        test_s_write_inval;
        test_own_core;
        test_tag_mismatch;
        test_back_to_back;
        test_random;
        test_wb_stall_overrun;
        test_reset_mid_wb;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
